// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan driver.
// Holds the raw (active-low) segment patterns for the hex digits 0-F and blank.
// Segment bit order is {g,f,e,d,c,b,a}, so bit 0 drives segment a.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_HEX_0 = 7'b1000000;
  localparam seg7_t SEG_HEX_1 = 7'b1111001;
  localparam seg7_t SEG_HEX_2 = 7'b0100100;
  localparam seg7_t SEG_HEX_3 = 7'b0110000;
  localparam seg7_t SEG_HEX_4 = 7'b0011001;
  localparam seg7_t SEG_HEX_5 = 7'b0010010;
  localparam seg7_t SEG_HEX_6 = 7'b0000010;
  localparam seg7_t SEG_HEX_7 = 7'b1111000;
  localparam seg7_t SEG_HEX_8 = 7'b0000000;
  localparam seg7_t SEG_HEX_9 = 7'b0010000;
  localparam seg7_t SEG_HEX_A = 7'b0001000;
  localparam seg7_t SEG_HEX_B = 7'b0000011;
  localparam seg7_t SEG_HEX_C = 7'b1000110;
  localparam seg7_t SEG_HEX_D = 7'b0100001;
  localparam seg7_t SEG_HEX_E = 7'b0000110;
  localparam seg7_t SEG_HEX_F = 7'b0001110;
  localparam seg7_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to raw (active-low) segment pattern.
// Ports:
//   nibble  - 4-bit hex value 0-F
//   seg_raw - active-low segment pattern {g,f,e,d,c,b,a}
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg_raw
);

  always_comb begin
    seg_raw = SEG_BLANK;
    case (nibble)
      4'h0: seg_raw = SEG_HEX_0;
      4'h1: seg_raw = SEG_HEX_1;
      4'h2: seg_raw = SEG_HEX_2;
      4'h3: seg_raw = SEG_HEX_3;
      4'h4: seg_raw = SEG_HEX_4;
      4'h5: seg_raw = SEG_HEX_5;
      4'h6: seg_raw = SEG_HEX_6;
      4'h7: seg_raw = SEG_HEX_7;
      4'h8: seg_raw = SEG_HEX_8;
      4'h9: seg_raw = SEG_HEX_9;
      4'hA: seg_raw = SEG_HEX_A;
      4'hB: seg_raw = SEG_HEX_B;
      4'hC: seg_raw = SEG_HEX_C;
      4'hD: seg_raw = SEG_HEX_D;
      4'hE: seg_raw = SEG_HEX_E;
      4'hF: seg_raw = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex display driver for a common-anode
// seven-segment bank. Scans NUM_DIGITS digits, each lit for REFRESH_DIV clocks.
// New values are double-buffered and committed only at frame wrap.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   value_in, load       - packed nibbles (digit 0 = LSB nibble) and capture strobe
//   blank_mask, dp_in    - per-digit forced blank / decimal point (live)
//   lz_suppress          - enable leading-zero blanking (live)
//   seg, dp, an          - registered segment, decimal point, one-hot anode outputs
//   frame_done           - registered one-cycle pulse per frame wrap
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_suppress,
  output seg7_t                   seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  // XOR masks that turn the internal active-low/active-high forms into the
  // board polarity selected by the parameters.
  localparam seg7_t                 SEG_POL = {7{~ACTIVE_LOW_SEG}};
  localparam logic                  DP_POL  = ~ACTIVE_LOW_SEG;
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW_AN}};

  logic [PRE_W-1:0]        pre_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic [4*NUM_DIGITS-1:0] pend_reg;
  logic                    pend_valid;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              nib [NUM_DIGITS];
  logic [3:0]              cur_nib;
  seg7_t                   dec_seg;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    all_zero;
  logic                    dark;
  logic [NUM_DIGITS-1:0]   an_onehot;
  seg7_t                   seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  assign tick = (pre_cnt == PRE_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = disp_reg[4*gi +: 4];
    end
  endgenerate

  // Walk down from the most significant digit; a digit is a leading zero
  // while every nibble from the top down to it is zero. Digit 0 is never dark.
  always_comb begin
    all_zero = 1'b1;
    lz_dark  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero && (nib[i] == 4'h0);
      lz_dark[i] = lz_suppress && all_zero;
    end
  end

  assign cur_nib = nib[idx];

  seg7_hex_decode u_decode (
    .nibble  (cur_nib),
    .seg_raw (dec_seg)
  );

  // A dark digit keeps its anode and decimal point; only the segments blank.
  always_comb begin
    an_onehot      = '0;
    an_onehot[idx] = 1'b1;
    dark           = blank_mask[idx] || lz_dark[idx];
    seg_next       = (dark ? SEG_BLANK : dec_seg) ^ SEG_POL;
    dp_next        = ~dp_in[idx] ^ DP_POL;
    an_next        = an_onehot ^ AN_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      idx        <= '0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_valid <= 1'b0;
      seg        <= SEG_BLANK ^ SEG_POL;
      dp         <= 1'b1 ^ DP_POL;
      an         <= AN_POL;
      frame_done <= 1'b0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end

      // Commit sees the pending value from before this edge, so a load on the
      // wrap cycle survives in pend_reg and is committed one frame later.
      if (wrap && pend_valid) begin
        disp_reg <= pend_reg;
      end
      if (load) begin
        pend_reg   <= value_in;
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end

      frame_done <= wrap;
      seg        <= seg_next;
      dp         <= dp_next;
      an         <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// Two instances share all inputs: one with active-low outputs, one with
// active-high outputs whose expected values are the bitwise inverses.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_in;
  logic        lz_suppress;

  logic [6:0]  seg_l, seg_h;
  logic        dp_l, dp_h;
  logic [3:0]  an_l, an_h;
  logic        fd_l, fd_h;

  int tests = 0;
  int fails = 0;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
    .blank_mask(blank_mask), .dp_in(dp_in), .lz_suppress(lz_suppress),
    .seg(seg_l), .dp(dp_l), .an(an_l), .frame_done(fd_l)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_AN(1'b0)
  ) dut_h (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
    .blank_mask(blank_mask), .dp_in(dp_in), .lz_suppress(lz_suppress),
    .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     value;
    logic            lz;
    logic [3:0]      mask;
    logic [3:0]      dpv;
    logic [3:0][6:0] exp_seg;   // element d = expected raw segments of digit d
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic [15:0] v, input logic lz, input logic [3:0] m,
                              input logic [3:0] d, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
    vec_t e;
    e.value = v; e.lz = lz; e.mask = m; e.dpv = d;
    e.exp_seg[0] = s0; e.exp_seg[1] = s1; e.exp_seg[2] = s2; e.exp_seg[3] = s3;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic e_fd);
    logic [3:0] e_an_h;
    logic [6:0] e_seg_h;
    logic       e_dp_h;
    e_an_h  = ~e_an;
    e_seg_h = ~e_seg;
    e_dp_h  = ~e_dp;
    chk({tag, " an"},    {28'd0, an_l},  {28'd0, e_an});
    chk({tag, " seg"},   {25'd0, seg_l}, {25'd0, e_seg});
    chk({tag, " dp"},    {31'd0, dp_l},  {31'd0, e_dp});
    chk({tag, " fd"},    {31'd0, fd_l},  {31'd0, e_fd});
    chk({tag, " an_h"},  {28'd0, an_h},  {28'd0, e_an_h});
    chk({tag, " seg_h"}, {25'd0, seg_h}, {25'd0, e_seg_h});
    chk({tag, " dp_h"},  {31'd0, dp_h},  {31'd0, e_dp_h});
    chk({tag, " fd_h"},  {31'd0, fd_h},  {31'd0, e_fd});
  endtask

  // Checks one digit slot at step s (1..16) of a frame that shows entry e.
  task automatic check_slot(input string label, input vec_t e, input int s);
    int         d;
    logic [3:0] e_an;
    d    = (s - 1) / 4;
    e_an = 4'b1111;
    e_an[d] = 1'b0;
    check_out($sformatf("%s s%0d", label, s), e_an, e.exp_seg[d], ~e.dpv[d], (s == 16));
  endtask

  // Runs one full frame (16 cycles) starting right after a wrap, checking
  // every cycle against entry e. Loads are driven after step la1/la2 (0 = none).
  task automatic run_frame(input string label, input vec_t e,
                           input int la1, input logic [15:0] lv1,
                           input int la2, input logic [15:0] lv2);
    blank_mask  = e.mask;
    dp_in       = e.dpv;
    lz_suppress = e.lz;
    for (int s = 1; s <= 16; s++) begin
      step();
      check_slot(label, e, s);
      load = 1'b0;
      if (s == la1) begin load = 1'b1; value_in = lv1; end
      if (s == la2) begin load = 1'b1; value_in = lv2; end
    end
    $display("[TB] frame %s: expected display %h lz=%0b mask=%b dp=%b", label, e.value, e.lz, e.mask, e.dpv);
  endtask

  vec_t e_plain1234, e_beef, e_1111, e_2222, e_zero;

  initial begin
    // Expected raw segment patterns hand-written per digit 0..3.
    tbl[0]  = mk(16'h0000, 0, 4'b0000, 4'b0000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    tbl[1]  = mk(16'hA5F0, 0, 4'b0000, 4'b0000, 7'b1000000, 7'b0001110, 7'b0010010, 7'b0001000);
    tbl[2]  = mk(16'h3210, 0, 4'b0000, 4'b0000, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000);
    tbl[3]  = mk(16'h7654, 0, 4'b0000, 4'b0000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000);
    tbl[4]  = mk(16'hBA98, 0, 4'b0000, 4'b0000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011);
    tbl[5]  = mk(16'hFEDC, 0, 4'b0000, 4'b0000, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110);
    tbl[6]  = mk(16'h0007, 1, 4'b0000, 4'b0000, 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);
    tbl[7]  = mk(16'h0000, 1, 4'b0000, 4'b0000, 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
    tbl[8]  = mk(16'h0000, 0, 4'b0000, 4'b0000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    tbl[9]  = mk(16'h0107, 1, 4'b0000, 4'b0000, 7'b1111000, 7'b1000000, 7'b1111001, 7'b1111111);
    tbl[10] = mk(16'h1234, 0, 4'b0100, 4'b0001, 7'b0011001, 7'b0110000, 7'b1111111, 7'b1111001);
    tbl[11] = mk(16'h1234, 0, 4'b0100, 4'b0100, 7'b0011001, 7'b0110000, 7'b1111111, 7'b1111001);
    e_plain1234 = mk(16'h1234, 0, 4'b0000, 4'b0000, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
    e_beef      = mk(16'hBEEF, 0, 4'b0000, 4'b0000, 7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011);
    e_1111      = mk(16'h1111, 0, 4'b0000, 4'b0000, 7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001);
    e_2222      = mk(16'h2222, 0, 4'b0000, 4'b0000, 7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100);
    e_zero      = tbl[0];

    rst_n = 1'b0; load = 1'b0; value_in = 16'h0000;
    blank_mask = 4'b0000; dp_in = 4'b0000; lz_suppress = 1'b0;

    // Reset state: all anodes off, segments blank, dp off, no frame pulse.
    step();
    step();
    check_out("reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    rst_n = 1'b1;

    // Frame i displays entry i and loads entry i+1 mid-frame.
    for (int i = 0; i < 12; i++) begin
      if (i < 11) run_frame($sformatf("tbl%0d", i), tbl[i], 5, tbl[i+1].value, 0, 16'h0);
      else        run_frame($sformatf("tbl%0d", i), tbl[i], 0, 16'h0, 0, 16'h0);
    end

    // Two loads in one frame: last one wins.
    run_frame("twoload", e_plain1234, 3, 16'h1234, 8, 16'hBEEF);
    // Load mid-frame, then another on the exact wrap cycle.
    run_frame("beef", e_beef, 5, 16'h1111, 15, 16'h2222);
    run_frame("oldpend", e_1111, 0, 16'h0, 0, 16'h0);

    // Reset mid-frame with a pending value, plus a load during reset.
    for (int s = 1; s <= 8; s++) begin
      step();
      check_slot("newpend", e_2222, s);
      load = (s == 5);
      if (s == 5) value_in = 16'h3333;
    end
    rst_n = 1'b0; load = 1'b1; value_in = 16'h4444;
    step();
    check_out("midreset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    $display("[TB] mid-frame reset applied with pending 3333 and load 4444");
    rst_n = 1'b1; load = 1'b0;
    run_frame("postrst0", e_zero, 0, 16'h0, 0, 16'h0);
    run_frame("postrst1", e_zero, 0, 16'h0, 0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed, parametrised hex display driver for the board's common-anode seven-segment bank. It takes a packed vector of `NUM_DIGITS` nibbles and decodes each to the full hexadecimal range 0–F. It scans the digits one at a time at a programmable refresh rate and supports per-digit blanking, decimal points and leading-zero suppression. New values are double-buffered and committed only at frame boundaries, so the display never shows a mix of old and new digits; the processor's debug/result path drives it.

## Interface
- `NUM_DIGITS`, 4, number of digits scanned; legal range 1–8.
- `REFRESH_DIV`, 50000, clock cycles each digit is lit; legal range ≥ 1.
- `ACTIVE_LOW_SEG`, 1, 1: segment/dp outputs active-low; 0: active-high.
- `ACTIVE_LOW_AN`, 1, 1: anode outputs active-low; 0: active-high.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `value_in`  in  4*NUM_DIGITS  packed nibbles; nibble i = digit i; digit 0 is least significant.
- `load`  in  1  single-cycle strobe; captures `value_in` into the pending buffer.
- `blank_mask`  in  NUM_DIGITS  bit i=1 forces digit i dark; sampled live.
- `dp_in`  in  NUM_DIGITS  bit i=1 lights the decimal point of digit i; sampled live.
- `lz_suppress`  in  1  1 enables leading-zero blanking; sampled live.
- `seg`  out  7  segments {g,f,e,d,c,b,a}; bit0 = a.
- `dp`  out  1  decimal point.
- `an`  out  NUM_DIGITS  one-hot digit enable.
- `frame_done`  out  1  one-cycle pulse on each frame wrap.

## Operation
- State:
  - prescaler `pre_cnt` (0..REFRESH_DIV-1);
  - digit index `idx` (0..NUM_DIGITS-1);
  - `pend_reg`/`pend_valid`;
  - display register `disp_reg`.
- tick = (pre_cnt == REFRESH_DIV-1). On tick, `pre_cnt` returns to 0 and `idx` advances. At NUM_DIGITS-1 it wraps to 0. Otherwise `pre_cnt` increments.
- Wrap = tick && idx == NUM_DIGITS-1. On wrap:
  - `frame_done` is 1 next cycle.
  - If `pend_valid`, then `disp_reg` ← `pend_reg` and `pend_valid` ← 0.
- `load` sets `pend_reg` ← `value_in` and `pend_valid` ← 1.
- Multiple loads within a frame: the last one wins.
- Load coincident with wrap: the commit uses the old `pend_reg`. The new value lands in `pend_reg` and `pend_valid` stays 1, so it is committed at the next wrap.
- Decode, raw active-low form:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- `ACTIVE_LOW_SEG`=0 inverts `seg` and `dp`. `ACTIVE_LOW_AN`=0 inverts `an`.
- Leading zero rule: digit i (i>0) is dark when `lz_suppress`=1 and nibbles NUM_DIGITS-1 down to i of `disp_reg` are all zero. Digit 0 is never leading-zero blanked.
- Dark digit (mask or leading zero): segments are blank and the dp follows `dp_in`. The anode stays enabled.

## Timing
- `seg`, `dp`, `an` and `frame_done` are registered.
- Outputs at cycle t+1 reflect `idx`, `disp_reg` and the live inputs at cycle t: one-cycle latency.
- Reset (`rst_n`=0 at a clock edge):
  - `pre_cnt`=0, `idx`=0, `disp_reg`=0, `pend_reg`=0, `pend_valid`=0;
  - `an` all inactive, `seg` blank, `dp` off, `frame_done`=0.
- Reset mid-frame discards any pending value. A `load` during reset is ignored.
- First active edge after reset release: `an` selects digit 0 showing "0".
- Each digit is lit for exactly REFRESH_DIV cycles. A frame lasts NUM_DIGITS*REFRESH_DIV cycles.
- `frame_done` period equals one frame.
- A committed value is visible in the cycle after the wrap edge.
- Worst-case latency from `load` to display is 1 + NUM_DIGITS*REFRESH_DIV cycles.
- REFRESH_DIV=1: `idx` advances every cycle. NUM_DIGITS=1: every tick is a wrap.

## Structure
- Package `seg7_pkg`:
  - 7-bit constants `SEG_HEX_0` … `SEG_HEX_F` and `SEG_BLANK`;
  - function-free typedef `seg7_t` (logic [6:0]).
- Sub-module `seg7_hex_decode`: combinational nibble → `seg7_t` using the package constants.
- Top level: prescaler, index counter, double buffer, leading-zero logic, output registers.

## Test plan
- Reset release, ND=4, RD=4, no load → `an`=1110 and `seg`=1000000. `an` rotates 1110→1101→1011→0111 every 4 cycles. `frame_done` pulses every 16 cycles.
- `load` with `value_in`=16'hA5F0 mid-frame → no change until the wrap. Next frame shows digits 0,F,5,A as 1000000, 0001110, 0010010, 0001000.
- `load` 16'h1234, then `load` 16'hBEEF in the same frame → only BEEF is ever shown. `load` on the exact wrap cycle → the old pending value is shown, and the new one appears a frame later.
- `disp_reg`=16'h0007, `lz_suppress`=1 → digits 3..1 blank and digit 0 shows 7. With 16'h0000 → only digit 0 shows "0". With `lz_suppress`=0 → all zeros shown.
- `blank_mask`=4'b0100, `dp_in`=4'b0001 → digit 2 segments 1111111. `dp` is low only while digit 0 is lit.
- Assert `rst_n` mid-frame with `pend_valid`=1 → outputs go dark next edge and the pending value is discarded. Repeat with ACTIVE_LOW_SEG=0 and ACTIVE_LOW_AN=0 → all polarities are inverted.
